count_enable_gen: RTL
=====================

// Module: count_enable_gen
// PURPOSE
//  Programmable tick generator that drives the enable input of the 4-bit down counter.
//  It divides clk by (div_reg+1) and issues single-cycle enable pulses.
//  Continuous mode runs until stopped; burst mode issues exactly burst_len ticks, then pulses done.
//  A burst of 16 walks the counter through one full pass from 15 to 0.
// PARAMETERS
//  DIV_W        8   width of divisor register / prescale counter
//  DIV_DEFAULT  9   divisor value after reset (tick period = DIV_DEFAULT+1 cycles)
//  BURST_W      5   width of burst length / remaining-tick counter
// PORTS
//  clk        in   1        single clock, all logic on posedge
//  reset      in   1        synchronous, active-high reset
//  start      in   1        start request, sampled on posedge; honoured only in IDLE
//  stop       in   1        stop request, sampled on posedge; forces IDLE
//  mode       in   1        0 = continuous, 1 = burst; sampled with start
//  div_val    in   DIV_W    divisor to load
//  div_load   in   1        loads div_val into div_reg; honoured only in IDLE
//  burst_len  in   BURST_W  tick count for burst; sampled with start
//  enable     out  1        registered tick, high for exactly one cycle per period
//  busy       out  1        high while state != IDLE
//  done       out  1        registered 1-cycle pulse at burst completion
// BEHAVIOUR
//  - Reset values: state=IDLE, enable=0, done=0, busy=0, pcnt=0, burst_rem=0, div_reg=DIV_DEFAULT.
//    Reset overrides every other input.
//  - States: IDLE, RUN (continuous), BURST.
//    * IDLE -> RUN: start & !stop & mode=0.
//    * IDLE -> BURST: start & !stop & mode=1 & burst_len!=0.
//    * RUN/BURST -> IDLE: on stop, or on the final burst tick.
//  - Start with mode=1 and burst_len=0: state stays IDLE and done pulses 1 cycle; no enable.
//  - On the start edge: pcnt <= div_reg; in burst mode, burst_rem <= burst_len.
//  - Each edge in RUN/BURST:
//    * pcnt==0: enable <= 1, pcnt <= div_reg.
//    * otherwise: enable <= 0, pcnt <= pcnt-1.
//  - Timing: start sampled at edge k -> first enable high after edge k+div_reg+1.
//    Subsequent ticks every div_reg+1 cycles. div_reg=0 -> enable high every cycle.
//  - Burst: each tick decrements burst_rem.
//    * The tick issued with burst_rem==1 also sets done <= 1 and state <= IDLE.
//    * done is coincident with the last enable; busy is low in that same cycle.
//  - stop in RUN/BURST: state <= IDLE, enable <= 0 at that edge, even if pcnt==0 (stop beats tick).
//    done is not asserted on stop.
//  - start and stop in the same IDLE cycle: stop wins, state stays IDLE.
//  - start while busy: ignored.
//  - div_load while busy: ignored, div_reg unchanged. div_load together with start in IDLE:
//    the new div_val is used as the first period.
//  - busy is combinational from the state register (state != IDLE).
//  - enable and done are 0 in every cycle not specified above. All arithmetic is unsigned with no wrap:
//    pcnt is never decremented at 0.
// CONFIGURATION
//  TICK_GATE_EN defined: adds input port gate (1 bit), placed after div_load.
//    * In RUN/BURST with gate=0: pcnt and burst_rem hold, enable=0. Counting resumes when gate=1.
//    * stop and reset still act while gated.
//  TICK_GATE_EN undefined: no gate port; counting is never frozen.
// TESTING
//  1. Reset: hold reset 2 cycles -> enable/done/busy all 0. Start continuous with default div 9
//     -> enable pulses every 10 cycles, first pulse 10 cycles after the start edge.
//  2. div_load=1 with div_val=0 in IDLE, then start -> enable high every cycle.
//     div_load=5 while RUN -> period unchanged.
//  3. div=3, mode=1, burst_len=16 -> exactly 16 pulses spaced 4 cycles apart. done high with the
//     16th pulse, busy low in that cycle, no further pulses.
//  4. Continuous run, assert stop on the edge where pcnt==0 -> no enable pulse, busy low next cycle.
//     Also: start+stop together in IDLE -> stays IDLE.
//  5. Reset asserted mid-burst after 5 ticks -> all outputs 0 next cycle, div_reg back to 9.
//     A later start with burst_len=0 -> done pulse only, no enable.
//  6. TICK_GATE_EN, div=2, burst_len=3, gate low for 7 cycles mid-burst -> tick gap stretched by 7,
//     still exactly 3 ticks and one done pulse.

Source files
------------

// File: rtl/count_enable_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | count_enable_gen : programmable tick generator driving a counter enable  |
// |   Continuous or fixed-length burst ticks at clk/(div_reg+1).             |
// |   Optional TICK_GATE_EN adds a gate input that freezes counting.         |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module count_enable_gen #(
   parameter int DIV_W       = 8,
   parameter int DIV_DEFAULT = 9,
   parameter int BURST_W     = 5
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               stop,
   input  logic               mode,
   input  logic [DIV_W-1:0]   div_val,
   input  logic               div_load,
`ifdef TICK_GATE_EN
   input  logic               gate,
`endif
   input  logic [BURST_W-1:0] burst_len,
   output logic               enable,
   output logic               busy,
   output logic               done
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_BURST = 2'd2
   } state_t;

   localparam logic [DIV_W-1:0]   c_div_default = DIV_W'(DIV_DEFAULT);
   localparam logic [BURST_W-1:0] c_burst_one   = BURST_W'(1);

   state_t             r_state, w_state_nx;
   logic [DIV_W-1:0]   r_pcnt, w_pcnt_nx;
   logic [DIV_W-1:0]   r_div, w_div_nx;
   logic [BURST_W-1:0] r_burst_rem, w_burst_rem_nx;
   logic               r_enable, w_enable_nx;
   logic               r_done, w_done_nx;
   logic               w_gate;
   logic [DIV_W-1:0]   w_div_eff;

`ifdef TICK_GATE_EN
   assign w_gate = gate;
`else
   assign w_gate = 1'b1;
`endif

   // A div_load coinciding with start supplies the very first period.
   assign w_div_eff = div_load ? div_val : r_div;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_pcnt      <= '0;
         r_div       <= c_div_default;
         r_burst_rem <= '0;
         r_enable    <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_state     <= w_state_nx;
         r_pcnt      <= w_pcnt_nx;
         r_div       <= w_div_nx;
         r_burst_rem <= w_burst_rem_nx;
         r_enable    <= w_enable_nx;
         r_done      <= w_done_nx;
      end
   end

   always_comb begin
      w_state_nx     = r_state;
      w_pcnt_nx      = r_pcnt;
      w_div_nx       = r_div;
      w_burst_rem_nx = r_burst_rem;
      w_enable_nx    = 1'b0;
      w_done_nx      = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (div_load) begin
               w_div_nx = div_val;
            end
            if (start && !stop) begin
               if (!mode) begin
                  w_state_nx = ST_RUN;
                  w_pcnt_nx  = w_div_eff;
               end else if (burst_len != '0) begin
                  w_state_nx     = ST_BURST;
                  w_pcnt_nx      = w_div_eff;
                  w_burst_rem_nx = burst_len;
               end else begin
                  // Empty burst completes immediately without any tick.
                  w_done_nx = 1'b1;
               end
            end
         end

         ST_RUN, ST_BURST: begin
            // stop takes priority over a tick falling on the same edge.
            if (stop) begin
               w_state_nx = ST_IDLE;
            end else if (w_gate) begin
               if (r_pcnt == '0) begin
                  w_enable_nx = 1'b1;
                  w_pcnt_nx   = r_div;
                  if (r_state == ST_BURST && r_burst_rem != '0) begin
                     w_burst_rem_nx = r_burst_rem - c_burst_one;
                     if (r_burst_rem == c_burst_one) begin
                        w_done_nx  = 1'b1;
                        w_state_nx = ST_IDLE;
                     end
                  end
               end else begin
                  w_pcnt_nx = r_pcnt - DIV_W'(1);
               end
            end
         end

         default: begin
            w_state_nx = ST_IDLE;
         end
      endcase
   end

   assign enable = r_enable;
   assign done   = r_done;
   assign busy   = (r_state != ST_IDLE);

endmodule
`default_nettype wire
